// File: rtl/armv4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : armv4_pkg
//  Brief    : Shared ARMv4 constants for the block-transfer datapath:
//             transfer stride default, register-bank size and the
//             LDM/STM sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package armv4_pkg;

  // Byte distance between consecutive block-transfer words.
  localparam int unsigned C_STRIDE_DEFAULT = 4;

  // Number of architectural registers addressable by a block transfer.
  localparam int unsigned C_REG_COUNT = 16;

  // LDM/STM sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBACK = 2'd2,
    ST_DONE  = 2'd3
  } ldm_state_e;

endpackage
`default_nettype wire

// File: rtl/lsb_find.sv
`default_nettype none
// ============================================================================
//  Module   : lsb_find
//  Brief    : Lowest-set-bit finder, 16-bit vector to 4-bit index plus a
//             valid flag. Index is 0 when the vector is empty.
//  Revision : 1.0  initial release
// ============================================================================
module lsb_find
  import armv4_pkg::*;
(
  input  logic [15:0] i_vec,
  output logic [3:0]  o_idx,
  output logic        o_valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = 4'd0;
    o_valid = 1'b0;
    for (int i = int'(C_REG_COUNT) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ldm_stm_sequencer
//  Brief    : Sequences an ARM LDM/STM block transfer: walks the register
//             mask lowest index first, issues one memory request per
//             register, strobes the register bank on loads and performs the
//             optional base-register writeback.
//  Revision : 1.0  initial release
// ============================================================================
module ldm_stm_sequencer
  import armv4_pkg::*;
#(
  parameter int unsigned STRIDE = C_STRIDE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        writeback,
  input  logic [15:0] reg_list,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  reg_idx,
  output logic        latch_reg,
  output logic        data_sel,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] C_STRIDE = 32'(STRIDE);

  ldm_state_e  state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic        is_load_q, is_load_d;
  logic        wb_eff_q, wb_eff_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  reg_idx_q, reg_idx_d;
  logic        data_sel_q, data_sel_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  w_count;
  logic [31:0] w_span;
  logic [31:0] w_first_addr;
  logic [31:0] w_wb_val;
  logic [15:0] w_mask_rest;
  logic [3:0]  w_lsb_idx;
  logic        w_lsb_valid;

  // Register count of the incoming list and the byte span it covers.
  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < int'(C_REG_COUNT); i++) begin
      w_count = w_count + 5'(reg_list[i]);
    end
    w_span = C_STRIDE * {27'd0, w_count};
  end

  // Lowest address of the block and the final base value, for all four modes.
  always_comb begin
    unique case ({up, pre})
      2'b10:   w_first_addr = base_addr;                      // IA
      2'b11:   w_first_addr = base_addr + C_STRIDE;           // IB
      2'b00:   w_first_addr = base_addr - w_span + C_STRIDE;  // DA
      default: w_first_addr = base_addr - w_span;             // DB
    endcase
    w_wb_val = up ? (base_addr + w_span) : (base_addr - w_span);
  end

  // Remaining mask with the register currently on the bus removed.
  assign w_mask_rest = mask_q & (mask_q - 16'd1);

  // Next register to transfer is always the lowest bit of the next mask.
  lsb_find u_lsb_find (
    .i_vec   (mask_d),
    .o_idx   (w_lsb_idx),
    .o_valid (w_lsb_valid)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    is_load_d  = is_load_q;
    wb_eff_d   = wb_eff_q;
    base_reg_d = base_reg_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    reg_idx_d  = reg_idx_q;
    data_sel_d = data_sel_q;
    wb_data_d  = wb_data_q;
    busy_d     = busy_q;
    done_d     = done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_load_d  = is_load;
          base_reg_d = base_reg;
          // A load that includes the base register wins over writeback.
          wb_eff_d   = writeback & ~(is_load & reg_list[base_reg]);
          mask_d     = reg_list;
          wb_data_d  = w_wb_val;
          busy_d     = 1'b1;
          data_sel_d = 1'b0;
          if (w_lsb_valid) begin
            state_d    = ST_XFER;
            mem_req_d  = 1'b1;
            mem_we_d   = ~is_load;
            mem_addr_d = w_first_addr;
            reg_idx_d  = w_lsb_idx;
          end else begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            reg_idx_d = 4'd0;
          end
        end
      end

      ST_XFER: begin
        if (mem_ack) begin
          mask_d = w_mask_rest;
          if (w_lsb_valid) begin
            mem_addr_d = mem_addr_q + C_STRIDE;
            reg_idx_d  = w_lsb_idx;
          end else begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (wb_eff_q) begin
              state_d    = ST_WBACK;
              data_sel_d = 1'b1;
              reg_idx_d  = base_reg_q;
            end else begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              reg_idx_d = 4'd0;
            end
          end
        end
      end

      ST_WBACK: begin
        state_d    = ST_DONE;
        data_sel_d = 1'b0;
        done_d     = 1'b1;
        reg_idx_d  = 4'd0;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= 16'd0;
      is_load_q  <= 1'b0;
      wb_eff_q   <= 1'b0;
      base_reg_q <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      reg_idx_q  <= 4'd0;
      data_sel_q <= 1'b0;
      wb_data_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      is_load_q  <= is_load_d;
      wb_eff_q   <= wb_eff_d;
      base_reg_q <= base_reg_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      reg_idx_q  <= reg_idx_d;
      data_sel_q <= data_sel_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Bank strobe must coincide with the acknowledging cycle, so it is decoded.
  assign latch_reg = ((state_q == ST_XFER) & is_load_q & mem_ack) |
                     (state_q == ST_WBACK);

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign reg_idx  = reg_idx_q;
  assign data_sel = data_sel_q;
  assign wb_data  = wb_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldm_stm_sequencer
//  Brief    : Directed self-checking bench for ldm_stm_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        up;
  logic        pre;
  logic        writeback;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  reg_idx;
  logic        latch_reg;
  logic        data_sel;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  ldm_stm_sequencer #(.STRIDE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .writeback (writeback),
    .reg_list  (reg_list),
    .base_reg  (base_reg),
    .base_addr (base_addr),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .reg_idx   (reg_idx),
    .latch_reg (latch_reg),
    .data_sel  (data_sel),
    .wb_data   (wb_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every output must read zero (used under and right after reset).
  task automatic check_all_zero(input string tag);
    check_eq({tag, ".req"},   32'(mem_req),   32'd0);
    check_eq({tag, ".we"},    32'(mem_we),    32'd0);
    check_eq({tag, ".addr"},  mem_addr,       32'd0);
    check_eq({tag, ".idx"},   32'(reg_idx),   32'd0);
    check_eq({tag, ".latch"}, 32'(latch_reg), 32'd0);
    check_eq({tag, ".sel"},   32'(data_sel),  32'd0);
    check_eq({tag, ".wb"},    wb_data,        32'd0);
    check_eq({tag, ".busy"},  32'(busy),      32'd0);
    check_eq({tag, ".done"},  32'(done),      32'd0);
  endtask

  // Called at posedge+1: present a start, then scramble the inputs so the
  // rest of the transfer can only rely on what was captured.
  task automatic do_start(input bit ld, input bit u, input bit p, input bit wb,
                          input logic [15:0] list, input logic [3:0] br,
                          input logic [31:0] base);
    start     = 1'b1;
    is_load   = ld;
    up        = u;
    pre       = p;
    writeback = wb;
    reg_list  = list;
    base_reg  = br;
    base_addr = base;
    mem_ack   = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_load   = ~ld;
    up        = ~u;
    pre       = ~p;
    writeback = ~wb;
    reg_list  = 16'hFFFF;
    base_reg  = ~br;
    base_addr = 32'hDEAD_BEEF;
  endtask

  // One cycle: drive start/ack, check the outputs of this cycle, advance.
  task automatic step(input string tag, input bit st, input bit ack,
                      input bit e_req, input bit e_we, input logic [31:0] e_addr,
                      input logic [3:0] e_idx, input bit e_latch, input bit e_sel,
                      input bit e_done, input bit e_busy);
    start   = st;
    mem_ack = ack;
    #1;
    check_eq({tag, ".req"},   32'(mem_req),   32'(e_req));
    check_eq({tag, ".latch"}, 32'(latch_reg), 32'(e_latch));
    check_eq({tag, ".done"},  32'(done),      32'(e_done));
    check_eq({tag, ".busy"},  32'(busy),      32'(e_busy));
    if (e_req) begin
      check_eq({tag, ".we"},   32'(mem_we),  32'(e_we));
      check_eq({tag, ".addr"}, mem_addr,     e_addr);
    end
    if (e_req || e_latch) begin
      check_eq({tag, ".idx"}, 32'(reg_idx),  32'(e_idx));
      check_eq({tag, ".sel"}, 32'(data_sel), 32'(e_sel));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_load   = 1'b0;
    up        = 1'b0;
    pre       = 1'b0;
    writeback = 1'b0;
    reg_list  = 16'h0000;
    base_reg  = 4'd0;
    base_addr = 32'd0;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LDM IA, base 0x100, R0,R1,R3; start held during DONE must be ignored.
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 16'h000B, 4'd5, 32'h0000_0100);
    check_eq("ia.wb_data", wb_data, 32'h0000_010C);
    step("ia.c1", 0, 1, 1, 0, 32'h100, 4'd0,  1, 0, 0, 1);
    step("ia.c2", 0, 1, 1, 0, 32'h104, 4'd1,  1, 0, 0, 1);
    step("ia.c3", 0, 1, 1, 0, 32'h108, 4'd3,  1, 0, 0, 1);
    step("ia.c4", 1, 1, 0, 0, 32'h0,   4'd0,  0, 0, 1, 1);
    step("ia.c5", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 0, 0);
    step("ia.c6", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 0, 0);

    // STM DB with writeback, base R13 = 0x200, R14/R15.
    do_start(1'b0, 1'b0, 1'b1, 1'b1, 16'hC000, 4'd13, 32'h0000_0200);
    check_eq("db.wb_data", wb_data, 32'h0000_01F8);
    step("db.c1", 0, 1, 1, 1, 32'h1F8, 4'd14, 0, 0, 0, 1);
    step("db.c2", 0, 1, 1, 1, 32'h1FC, 4'd15, 0, 0, 0, 1);
    step("db.wbk", 0, 1, 0, 0, 32'h0,  4'd13, 1, 1, 0, 1);
    check_eq("db.wb_hold", wb_data, 32'h0000_01F8);
    step("db.c4", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 1, 1);
    step("db.c5", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 0, 0);

    // LDM IB with writeback, base R2 also in the list: no writeback cycle.
    do_start(1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 4'd2, 32'h0000_0300);
    check_eq("ib.wb_data", wb_data, 32'h0000_0308);
    step("ib.c1", 0, 1, 1, 0, 32'h304, 4'd1,  1, 0, 0, 1);
    step("ib.c2", 0, 1, 1, 0, 32'h308, 4'd2,  1, 0, 0, 1);
    step("ib.c3", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 1, 1);
    step("ib.c4", 0, 1, 0, 0, 32'h0,   4'd0,  0, 0, 0, 0);

    // Empty list: straight to DONE, no traffic, no writeback.
    do_start(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd4, 32'h0000_0400);
    check_eq("nil.wb_data", wb_data, 32'h0000_0400);
    step("nil.c1", 0, 1, 0, 0, 32'h0,  4'd0,  0, 0, 1, 1);
    step("nil.c2", 0, 1, 0, 0, 32'h0,  4'd0,  0, 0, 0, 0);

    // LDM DA, R0/R4/R8 from base 0x1000; second transfer stalls 3 cycles
    // with start asserted, which must be ignored.
    do_start(1'b1, 1'b0, 1'b0, 1'b0, 16'h0111, 4'd0, 32'h0000_1000);
    check_eq("da.wb_data", wb_data, 32'h0000_0FF4);
    step("da.c1",  0, 1, 1, 0, 32'hFF8,  4'd0, 1, 0, 0, 1);
    step("da.s1",  1, 0, 1, 0, 32'hFFC,  4'd4, 0, 0, 0, 1);
    step("da.s2",  1, 0, 1, 0, 32'hFFC,  4'd4, 0, 0, 0, 1);
    step("da.s3",  1, 0, 1, 0, 32'hFFC,  4'd4, 0, 0, 0, 1);
    step("da.c2",  0, 1, 1, 0, 32'hFFC,  4'd4, 1, 0, 0, 1);
    step("da.c3",  0, 1, 1, 0, 32'h1000, 4'd8, 1, 0, 0, 1);
    step("da.c4",  0, 1, 0, 0, 32'h0,    4'd0, 0, 0, 1, 1);
    step("da.c5",  0, 1, 0, 0, 32'h0,    4'd0, 0, 0, 0, 0);

    // Reset during the second of three loads.
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 16'h0007, 4'd0, 32'h0000_0500);
    step("rst.c1", 0, 1, 1, 0, 32'h500, 4'd0, 1, 0, 0, 1);
    mem_ack = 1'b0;
    #1;
    check_eq("rst.mid.addr", mem_addr, 32'h0000_0504);
    check_eq("rst.mid.idx",  32'(reg_idx), 32'd1);
    #1;
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    check_all_zero("rst.now");
    @(posedge clk);
    #1;
    check_all_zero("rst.held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst.idle", 0, 1, 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

    // Fresh transfer after reset release.
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 4'd0, 32'h0000_0600);
    check_eq("post.wb_data", wb_data, 32'h0000_0608);
    step("post.c1", 0, 1, 1, 0, 32'h600, 4'd0, 1, 0, 0, 1);
    step("post.c2", 0, 1, 1, 0, 32'h604, 4'd1, 1, 0, 0, 1);
    step("post.c3", 0, 1, 0, 0, 32'h0,   4'd0, 0, 0, 1, 1);
    step("post.c4", 0, 1, 0, 0, 32'h0,   4'd0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
